// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// The winner's transaction fields are latched onto the controller inputs, the
// execute/busy handshake is driven, and read data plus a one-hot completion
// pulse are returned.
// Optional: define I2C_ARB_TIMEOUT_EN to build the LAUNCH start timeout and err_o.
module i2c_bus_arbiter #(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned START_TIMEOUT = 4096
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [7*NUM_REQ-1:0]   addr_i,
   input  logic [NUM_REQ-1:0]     rw_i,
   input  logic [8*NUM_REQ-1:0]   reg_id_i,
   input  logic [8*NUM_REQ-1:0]   reg_val_i,
   input  logic [NUM_REQ-1:0]     send_val_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [NUM_REQ-1:0]     done_o,
   output logic                   err_o,
   output logic [7:0]             rdata_o,
   output logic [6:0]             address_o,
   output logic                   rw_o,
   output logic [7:0]             register_id_o,
   output logic [7:0]             register_value_o,
   output logic                   send_register_value_o,
   output logic                   execute_o,
   input  logic                   busy_i,
   input  logic [7:0]             register_value_i
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StLaunch, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    ptr_q, own_q, own_next, win_idx;
   logic               win_valid;
   logic [NUM_REQ-1:0] win_onehot;
   logic               finish;
   logic               tmo_hit;
   int                 cand;

   logic [NUM_REQ-1:0] gnt_q, done_q;
   logic [7:0]         rdata_q;
   logic [6:0]         address_q;
   logic               rw_q, send_q, execute_q;
   logic [7:0]         reg_id_q, reg_val_q;

   logic [6:0]         addr_a    [NUM_REQ];
   logic [7:0]         reg_id_a  [NUM_REQ];
   logic [7:0]         reg_val_a [NUM_REQ];

   // Split the packed per-requester buses into indexable slices
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         addr_a[k]    = addr_i[7*k +: 7];
         reg_id_a[k]  = reg_id_i[8*k +: 8];
         reg_val_a[k] = reg_val_i[8*k +: 8];
      end
   end

   // Round-robin search: first set request at or after the pointer, wrapping
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr_q) + i) % int'(NUM_REQ);
         if (!win_valid && req_i[IdxW'(cand)]) begin
            win_valid = 1'b1;
            win_idx   = IdxW'(cand);
         end
      end
   end

   // Winner one-hot and the pointer value after the current owner finishes
   always_comb begin
      win_onehot = NUM_REQ'(1) << win_idx;
      own_next   = (own_q == IdxW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(START_TIMEOUT) + 1;

   logic [TmoW-1:0] tmo_q;
   logic            err_q;

   assign tmo_hit = (tmo_q == TmoW'(START_TIMEOUT - 1));

   // Start timeout counter; held at zero outside LAUNCH so entry always starts clean
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else if (state_q != StLaunch) begin
         tmo_q <= '0;
      end else if (!tmo_hit) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   // Error pulse accompanies done_o when the transaction ends straight from LAUNCH
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= finish && (state_q == StLaunch);
      end
   end

   assign err_o = err_q;
`else
   assign tmo_hit = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Next-state logic; busy_i high in IDLE blocks any new grant
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (win_valid && !busy_i) state_d = StLaunch;
         end
         StLaunch: begin
            if (busy_i) begin
               state_d = StRun;
            end else if (tmo_hit) begin
               state_d = StDone;
            end
         end
         StRun: begin
            if (!busy_i) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign finish = (state_d == StDone) && (state_q != StDone);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant, controller-side field latch, execute handshake and completion
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         address_q <= '0;
         rw_q      <= 1'b0;
         reg_id_q  <= '0;
         reg_val_q <= '0;
         send_q    <= 1'b0;
         execute_q <= 1'b0;
         ptr_q     <= '0;
         own_q     <= '0;
      end else begin
         done_q <= '0;
         if ((state_q == StIdle) && (state_d == StLaunch)) begin
            gnt_q     <= win_onehot;
            own_q     <= win_idx;
            address_q <= addr_a[win_idx];
            rw_q      <= rw_i[win_idx];
            reg_id_q  <= reg_id_a[win_idx];
            reg_val_q <= reg_val_a[win_idx];
            send_q    <= send_val_i[win_idx];
            execute_q <= 1'b1;
         end
         // execute must be low before the controller drops busy
         if ((state_q == StLaunch) && (state_d != StLaunch)) begin
            execute_q <= 1'b0;
         end
         if (finish) begin
            done_q <= gnt_q;
            gnt_q  <= '0;
            ptr_q  <= own_next;
            if (rw_q) rdata_q <= register_value_i;
         end
      end
   end

   assign gnt_o                 = gnt_q;
   assign done_o                = done_q;
   assign rdata_o               = rdata_q;
   assign address_o             = address_q;
   assign rw_o                  = rw_q;
   assign register_id_o         = reg_id_q;
   assign register_value_o      = reg_val_q;
   assign send_register_value_o = send_q;
   assign execute_o             = execute_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: a table of single transactions plus
// hand-written sequences for busy-in-idle, reset mid-transaction and timeout.
module tb_i2c_bus_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req_i;
   logic [13:0] addr_i;
   logic [1:0] rw_i;
   logic [15:0] reg_id_i;
   logic [15:0] reg_val_i;
   logic [1:0] send_val_i;
   logic [1:0] gnt_o;
   logic [1:0] done_o;
   logic       err_o;
   logic [7:0] rdata_o;
   logic [6:0] address_o;
   logic       rw_o;
   logic [7:0] register_id_o;
   logic [7:0] register_value_o;
   logic       send_register_value_o;
   logic       execute_o;
   logic       busy_i;
   logic [7:0] register_value_i;

   int checks;
   int failures;

   i2c_bus_arbiter #(
      .NUM_REQ       (2),
      .START_TIMEOUT (16)
   ) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .req_i                 (req_i),
      .addr_i                (addr_i),
      .rw_i                  (rw_i),
      .reg_id_i              (reg_id_i),
      .reg_val_i             (reg_val_i),
      .send_val_i            (send_val_i),
      .gnt_o                 (gnt_o),
      .done_o                (done_o),
      .err_o                 (err_o),
      .rdata_o               (rdata_o),
      .address_o             (address_o),
      .rw_o                  (rw_o),
      .register_id_o         (register_id_o),
      .register_value_o      (register_value_o),
      .send_register_value_o (send_register_value_o),
      .execute_o             (execute_o),
      .busy_i                (busy_i),
      .register_value_i      (register_value_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [1:0] req_after;
      int         wait_cyc;
      logic [7:0] ctrl_rdata;
      logic [1:0] exp_gnt;
      logic [6:0] exp_addr;
      logic       exp_rw;
      logic [7:0] exp_reg;
      logic [7:0] exp_val;
      logic       exp_send;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Requester 0: write 0x55 to reg 0x06 at 0x40; requester 1: read reg 0x10 at 0x21
   task automatic set_fields();
      addr_i     = {7'h21, 7'h40};
      rw_i       = 2'b10;
      reg_id_i   = {8'h10, 8'h06};
      reg_val_i  = {8'h00, 8'h55};
      send_val_i = 2'b01;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic ok;
      req_i = v.req;
      set_fields();
      busy_i = 1'b0;
      register_value_i = 8'hEE;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", n), gnt_o, v.exp_gnt);
      chk($sformatf("v%0d_exec_rise", n), execute_o, 1'b1);
      chk($sformatf("v%0d_addr", n), address_o, v.exp_addr);
      chk($sformatf("v%0d_rw", n), rw_o, v.exp_rw);
      chk($sformatf("v%0d_reg", n), register_id_o, v.exp_reg);
      chk($sformatf("v%0d_val", n), register_value_o, v.exp_val);
      chk($sformatf("v%0d_send", n), send_register_value_o, v.exp_send);
      // Requester inputs may change freely after the grant
      req_i      = v.req_after;
      addr_i     = ~addr_i;
      rw_i       = ~rw_i;
      reg_id_i   = ~reg_id_i;
      reg_val_i  = ~reg_val_i;
      send_val_i = ~send_val_i;
      ok = 1'b1;
      for (int c = 0; c < v.wait_cyc; c++) begin
         @(negedge clk);
         if (execute_o !== 1'b1) ok = 1'b0;
      end
      chk($sformatf("v%0d_exec_hold", n), ok, 1'b1);
      busy_i = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_exec_drop", n), execute_o, 1'b0);
      chk($sformatf("v%0d_gnt_run", n), gnt_o, v.exp_gnt);
      ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done_o !== 2'b00) ok = 1'b0;
      end
      chk($sformatf("v%0d_no_early_done", n), ok, 1'b1);
      register_value_i = v.ctrl_rdata;
      busy_i = 1'b0;
      @(negedge clk);
      register_value_i = 8'hEE;
      chk($sformatf("v%0d_done", n), done_o, v.exp_gnt);
      chk($sformatf("v%0d_err", n), err_o, 1'b0);
      chk($sformatf("v%0d_rdata", n), rdata_o, v.exp_rdata);
      chk($sformatf("v%0d_gnt_clr", n), gnt_o, 2'b00);
      chk($sformatf("v%0d_addr_stable", n), address_o, v.exp_addr);
      chk($sformatf("v%0d_reg_stable", n), register_id_o, v.exp_reg);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", n), done_o, 2'b00);
      chk($sformatf("v%0d_idle_gnt", n), gnt_o, 2'b00);
   endtask

   // Short controller handshake used by the hand-written sequences
   task automatic finish_txn(input string name, input logic [1:0] exp_done);
      busy_i = 1'b1;
      @(negedge clk);
      busy_i = 1'b0;
      req_i  = 2'b00;
      @(negedge clk);
      chk({name, "_done"}, done_o, exp_done);
      @(negedge clk);
   endtask

   initial begin
      logic ok;
      int   hi;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req_i    = 2'b00;
      busy_i   = 1'b0;
      register_value_i = 8'h00;
      set_fields();

      vecs[0] = '{2'b01, 2'b00, 3, 8'h3C, 2'b01, 7'h40, 1'b0, 8'h06, 8'h55, 1'b1, 8'h00};
      vecs[1] = '{2'b10, 2'b00, 2, 8'hA7, 2'b10, 7'h21, 1'b1, 8'h10, 8'h00, 1'b0, 8'hA7};
      vecs[2] = '{2'b11, 2'b11, 4, 8'h11, 2'b01, 7'h40, 1'b0, 8'h06, 8'h55, 1'b1, 8'hA7};
      vecs[3] = '{2'b11, 2'b11, 1, 8'h5A, 2'b10, 7'h21, 1'b1, 8'h10, 8'h00, 1'b0, 8'h5A};
      vecs[4] = '{2'b11, 2'b11, 5, 8'h99, 2'b01, 7'h40, 1'b0, 8'h06, 8'h55, 1'b1, 8'h5A};
      vecs[5] = '{2'b11, 2'b00, 2, 8'hC3, 2'b10, 7'h21, 1'b1, 8'h10, 8'h00, 1'b0, 8'hC3};

      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_done", done_o, 2'b00);
      chk("rst_exec", execute_o, 1'b0);
      chk("rst_addr", address_o, 7'h00);
      chk("rst_rdata", rdata_o, 8'h00);
      chk("rst_err", err_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // busy_i already high in IDLE: no grant until it falls (pointer is 0 here)
      busy_i = 1'b1;
      req_i  = 2'b01;
      ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (gnt_o !== 2'b00) ok = 1'b0;
      end
      chk("busy_idle_nogrant", ok, 1'b1);
      busy_i = 1'b0;
      @(negedge clk);
      chk("busy_idle_grant", gnt_o, 2'b01);
      finish_txn("busy_idle", 2'b01);

      // Reset during RUN (pointer is 1 here)
      req_i = 2'b10;
      @(negedge clk);
      chk("rst_run_gnt", gnt_o, 2'b10);
      busy_i = 1'b1;
      @(negedge clk);
      rst_n  = 1'b0;
      busy_i = 1'b0;
      #1;
      chk("rst_run_exec", execute_o, 1'b0);
      chk("rst_run_gnt_drop", gnt_o, 2'b00);
      ok = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (done_o !== 2'b00) ok = 1'b0;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (done_o !== 2'b00) ok = 1'b0;
      chk("rst_run_no_done", ok, 1'b1);
      chk("rst_run_regrant", gnt_o, 2'b10);
      finish_txn("rst_run", 2'b10);

      // Start timeout (pointer is 0 here)
      req_i = 2'b01;
      @(negedge clk);
      chk("tmo_gnt", gnt_o, 2'b01);
`ifdef I2C_ARB_TIMEOUT_EN
      req_i = 2'b11;
      hi = (execute_o === 1'b1) ? 1 : 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (execute_o !== 1'b1) break;
         hi++;
      end
      chk("tmo_exec_cycles", hi, 16);
      chk("tmo_done", done_o, 2'b01);
      chk("tmo_err", err_o, 1'b1);
      @(negedge clk);
      chk("tmo_err_pulse", err_o, 1'b0);
      @(negedge clk);
      chk("tmo_ptr_adv", gnt_o, 2'b10);
      finish_txn("tmo_next", 2'b10);
`else
      ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (execute_o !== 1'b1 || done_o !== 2'b00 || err_o !== 1'b0) ok = 1'b0;
      end
      chk("notmo_wait", ok, 1'b1);
      busy_i = 1'b1;
      @(negedge clk);
      busy_i = 1'b0;
      req_i  = 2'b00;
      @(negedge clk);
      chk("notmo_done", done_o, 2'b01);
      chk("notmo_err", err_o, 1'b0);
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_controller between NUM_REQ on-chip requesters, e.g. the PWM register updater and the configuration loader.
- Arbitrates pending requests round-robin and latches the winner's transaction fields onto the controller inputs.
- Drives the controller's execute/busy handshake and returns read data plus a per-requester completion pulse.
- Sits between the requesters and the i2c_controller instance; all logic is in the clk_i domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- START_TIMEOUT, 4096, clk_i cycles to wait for busy_i to rise after execute_o is asserted.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester request level.
- addr_i  in  7*NUM_REQ  target address; slice k = [7k+6:7k].
- rw_i  in  NUM_REQ  1 = read.
- reg_id_i  in  8*NUM_REQ  register id.
- reg_val_i  in  8*NUM_REQ  write value.
- send_val_i  in  NUM_REQ  send register value phase.
- gnt_o  out  NUM_REQ  one-hot, high while the requester's transaction is owned.
- done_o  out  NUM_REQ  1-cycle completion pulse.
- err_o  out  1  1-cycle pulse with done_o on start timeout.
- rdata_o  out  8  read data, valid with done_o.
- address_o  out  7  to controller address_i.
- rw_o  out  1  to controller rw_i.
- register_id_o  out  8  to controller register_id_i.
- register_value_o  out  8  to controller register_value_i.
- send_register_value_o  out  1  to controller send_register_value_i.
- execute_o  out  1  to controller execute_i.
- busy_i  in  1  from controller busy_o.
- register_value_i  in  8  from controller register_value_ro.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Priority pointer 0.
- Reset mid-transaction: execute_o and gnt_o drop immediately. No done_o is issued. The controller is reset by the same rst_ni.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - If any req_i bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - On that edge, latch the winner's fields into the controller-side output registers and set gnt_o[k].
  - Go to LAUNCH next cycle. Arbitration latency is 1 cycle from req_i to gnt_o.
- LAUNCH:
  - execute_o = 1; hold it until busy_i = 1 is sampled.
  - The controller samples execute only on an internal SCL edge, so the hold lasts multiple cycles.
  - When busy_i = 1 is sampled, drop execute_o the same edge and go to RUN. execute_o must be low before busy_i falls, otherwise the controller restarts.
  - If the timeout counter reaches START_TIMEOUT-1, drop execute_o and go to DONE with the error flag set.
- RUN: wait for busy_i = 0, then go to DONE.
- DONE (1 cycle):
  - Pulse done_o[k].
  - rdata_o <= register_value_i if latched rw = 1, else rdata_o is unchanged.
  - err_o = error flag.
  - Clear gnt_o.
  - Pointer <= k+1 mod NUM_REQ.
  - Return to IDLE. A new grant may follow on the next cycle.
- Field stability: output fields are stable from the grant until DONE. Requester inputs may change freely after the grant.
- req_i dropped after grant: the transaction still completes and done_o still pulses.
- req_i held high after done: treated as a new request, subject to round-robin.
- Simultaneous requests: exactly one grant per cycle; no requester is starved beyond NUM_REQ-1 transactions.
- busy_i already high in IDLE (external misuse): no grant until busy_i = 0.
- Timeout counter: width $clog2(START_TIMEOUT)+1; cleared on entry to LAUNCH.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined: the LAUNCH timeout and err_o behave as above.
- Undefined: LAUNCH waits indefinitely for busy_i, the timeout counter is not built, and err_o is tied to 0.

Test Plan:
- req_i=01, addr 0x40, reg 0x06, val 0x55, rw=0, send_val=1 -> gnt_o=01 one cycle later; execute_o high until busy_i rises; done_o=01 after busy_i falls; err_o=0.
- req_i=11 held, then both requesters re-request -> grant order 0,1,0,1; each done_o pulse precedes the next grant.
- Requester 1 read: rw=1, controller model returns 0xA7 -> rdata_o=0xA7 on done_o=10.
- busy_i stuck at 0, START_TIMEOUT=16, macro defined -> execute_o drops after 16 cycles; done_o and err_o pulse together; pointer advances.
- rst_ni asserted during RUN -> execute_o=0, gnt_o=0, no done_o; after release, a new req_i is granted normally.
- Requester drops req_i during RUN -> transaction completes; done_o still pulses.
